// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the RV64I load/store unit: FSM states,
// access-size codes, strobe base patterns and alignment rules.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } lsu_state_e;

    // funct3[1:0] selects the access size; funct3[2] selects zero-extension.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [2:0] F3_BAD_LOAD = 3'b111;

    function automatic logic [7:0] strobe_base(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Combinational load extractor: selects the addressed byte lane of a
// doubleword and sign- or zero-extends it according to funct3.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [63:0] rdata_i,
    input  logic [2:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [63:0] data_o
);

    logic [63:0] lane;
    logic        sext;

    assign lane = rdata_i >> {off_i, 3'b000};
    assign sext = ~funct3_i[2];

    always_comb begin
        data_o = lane;
        case (funct3_i[1:0])
            SZ_B:    data_o = {{56{sext & lane[7]}},  lane[7:0]};
            SZ_H:    data_o = {{48{sext & lane[15]}}, lane[15:0]};
            SZ_W:    data_o = {{32{sext & lane[31]}}, lane[31:0]};
            default: data_o = lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Sequences one RV64I load or store against data memory: latches the request,
// issues an aligned doubleword access with strobes and extends load results.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            is_store_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [7:0]      mem_wstrb_o,
    output logic            mem_valid_o,
    output logic            mem_we_o,
    input  logic            mem_ready_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            error_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            reg_write_o
);

    localparam int CNT_W = $clog2(TIMEOUT);

    lsu_state_e      state_q, state_d;
    logic            is_store_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [7:0]      wstrb_q;
    logic [XLEN-1:0] load_data_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] ext_data;
    logic            illegal_start;
    logic            timeout_hit;

    load_extend u_load_extend (
        .rdata_i  (mem_rdata_i),
        .off_i    (addr_q[2:0]),
        .funct3_i (funct3_q),
        .data_o   (ext_data)
    );

    assign illegal_start = (is_store_i & funct3_i[2])
                         | (~is_store_i & (funct3_i == F3_BAD_LOAD))
                         | is_misaligned(funct3_i[1:0], addr_i[2:0]);
    assign timeout_hit   = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = illegal_start ? S_ERR : S_REQ;
            S_REQ: begin
                if (mem_ready_i)      state_d = S_DONE;
                else if (timeout_hit) state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_valid_o = (state_q == S_REQ);
        mem_we_o    = (state_q == S_REQ) & is_store_q;
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE) | (state_q == S_ERR);
        error_o     = (state_q == S_ERR);
        reg_write_o = (state_q == S_DONE) & ~is_store_q;
    end

    // Request registers stay frozen from acceptance until the next start in IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            is_store_q  <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            load_data_q <= '0;
        end else begin
            if (state_q == S_IDLE && start_i) begin
                is_store_q <= is_store_i;
                funct3_q   <= funct3_i;
                addr_q     <= addr_i;
                wdata_q    <= store_data_i << {addr_i[2:0], 3'b000};
                wstrb_q    <= is_store_i ? (strobe_base(funct3_i[1:0]) << addr_i[2:0]) : 8'h00;
            end
            if (state_q == S_REQ && mem_ready_i && !is_store_q) begin
                load_data_q <= ext_data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q != S_REQ && state_d == S_REQ) begin
            cnt_q <= '0;
        end else if (state_q == S_REQ && !mem_ready_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign mem_addr_o  = {addr_q[XLEN-1:3], 3'b000};
    assign mem_wdata_o = wdata_q;
    assign mem_wstrb_o = wstrb_q;
    assign load_data_o = load_data_q;

endmodule
